gpio_apb_regs: RTL
==================

Name: gpio_apb_regs

Overview:
- APB slave register block of the GPIO core; sits directly upstream of io_interface.
- Drives out_pad_o and oen_padoe_o into the pad stage, and consumes in_pad_i from it through a 2-flop synchronizer.
- Provides per-pin edge detection, sticky interrupt status and a single interrupt line.

Parameters:
- GPIO_W, 32, number of GPIO pins (1..32); all data registers are GPIO_W bits, zero-extended on PRDATA.
- ADDR_W, 8, width of PADDR; only bits [4:2] are decoded, bits [1:0] ignored.

Ports:
- PCLK  input  1  APB clock, single clock domain.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1=write, 0=read.
- PADDR  input  ADDR_W  byte address.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  tied 1 (zero wait states).
- PSLVERR  output  1  error on unmapped access.
- in_pad_i  input  GPIO_W  asynchronous pad inputs from io_interface.
- out_pad_o  output  GPIO_W  pad output values to io_interface.
- oen_padoe_o  output  GPIO_W  per-pin output enable to io_interface; 1 means the pin drives its pad.
- irq_o  output  1  interrupt request.

Behaviour:
- Reset (PRESET=1, asynchronous): all registers, synchronizer and edge flops = 0.
  - Outputs during reset: out_pad_o=0, oen_padoe_o=0 (all pins inputs), irq_o=0, PRDATA=0, PSLVERR=0.
  - Reset asserted mid-transfer aborts the transfer; no register update.
- Register map (offset, access, reset value 0):
  - 0x00 IN: RO, synchronized pin values.
  - 0x04 OUT: RW, drives out_pad_o.
  - 0x08 OE: RW, drives oen_padoe_o.
  - 0x0C INTE: RW, per-pin interrupt enable.
  - 0x10 PTRIG: RW, per-pin trigger edge; 1=rising, 0=falling.
  - 0x14 INTS: RW1C, sticky per-pin status.
  - 0x18 CTRL: RW, bit0 = global interrupt enable; bits 31:1 read 0.
- APB protocol:
  - Setup phase: PSEL=1, PENABLE=0, no effect.
  - Access phase: PSEL=1, PENABLE=1, PREADY=1, so every transfer completes in that cycle.
  - Writes commit on the PCLK rising edge ending the access phase.
  - Writes to IN are ignored with PSLVERR=0.
- Reads:
  - PRDATA is combinational from the current register values while PSEL=1 and PWRITE=0; otherwise 0.
  - Unused upper bits read 0.
- Unmapped offsets (0x1C, or any PADDR[ADDR_W-1:5] != 0):
  - PSLVERR=1 during the access phase only.
  - Reads return 0; writes are dropped.
- Output path: out_pad_o = OUT and oen_padoe_o = OE, driven directly from the flops, so the new value is visible the cycle after the write edge.
- Input path:
  - sync1 <= in_pad_i, then sync2 <= sync1. IN = sync2, giving a 2-cycle latency from a pad change to IN.
  - prev <= sync2.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
- Interrupt status:
  - event[i] = INTE[i] & (PTRIG[i] ? rise[i] : fall[i]).
  - INTS[i] <= event[i] | (INTS[i] & ~clr[i]), where clr = PWDATA on an INTS write, else 0.
  - A simultaneous set and clear on the same bit leaves it set.
  - Changing INTE or PTRIG does not clear INTS.
  - Edges on pins with INTE=0 are never recorded, even if INTE is enabled later.
- irq_o = CTRL[0] & |INTS, combinational from flops; deasserts the cycle after the clearing write.
- Pin direction does not gate edge detection; output pins loop back via in_pad_i and can interrupt.

Test Plan:
- Reset check: assert PRESET with PCLK running -> out_pad_o=0, oen_padoe_o=0, irq_o=0; all registers read 0 after release.
- Output drive: write OUT=0xDEADBEEF, OE=0x0000FFFF -> out_pad_o=0xDEADBEEF and oen_padoe_o=0x0000FFFF one cycle after each write; readback matches.
- Input sync latency: in_pad_i 0 -> 0xCAFEBABE at cycle N -> IN reads 0 at N+1 and 0xCAFEBABE from N+2.
- Rising edge and clear:
  - Setup: INTE=0x1, PTRIG=0x1, CTRL=0x1.
  - Stimulus: drive pin0 0->1.
  - Response: INTS=0x1 and irq_o=1 three cycles after the pad change.
  - Then write INTS=0x1 -> INTS=0 and irq_o=0 on the next cycle.
- Falling edge, masking and collision:
  - PTRIG=0: pin3 1->0 sets INTS bit3.
  - Pin4 toggles with INTE bit4=0 -> INTS bit4 stays 0.
  - Edge event coinciding with a W1C of the same bit -> bit remains 1.
- Errors and global gate:
  - Read 0x1C -> PSLVERR=1, PRDATA=0; write 0x00 -> IN unchanged, PSLVERR=0.
  - CTRL=0 with INTS!=0 -> irq_o=0.

Source files
------------

// File: rtl/gpio_apb_regs.sv
// APB register block for the GPIO core: pad output/enable registers, 2-flop input
// synchronizer, per-pin edge detection with sticky W1C status and one interrupt line.
module gpio_apb_regs #(
    parameter int GPIO_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [GPIO_W-1:0] in_pad_i,
    output logic [GPIO_W-1:0] out_pad_o,
    output logic [GPIO_W-1:0] oen_padoe_o,
    output logic              irq_o
);

    typedef enum logic [2:0] {
        A_IN    = 3'd0,
        A_OUT   = 3'd1,
        A_OE    = 3'd2,
        A_INTE  = 3'd3,
        A_PTRIG = 3'd4,
        A_INTS  = 3'd5,
        A_CTRL  = 3'd6,
        A_NONE  = 3'd7
    } reg_sel_e;

    logic [GPIO_W-1:0] r_out, r_oe, r_inte, r_ptrig, r_ints;
    logic [GPIO_W-1:0] r_sync1, r_sync2, r_prev;
    logic              r_ctrl;

    reg_sel_e          w_sel;
    logic              w_mapped, w_wr, w_unused_addr;
    logic [GPIO_W-1:0] w_rise, w_fall, w_event, w_clr;
    logic [31:0]       w_rdata;

    // Low address bits only select bytes within a word and are not decoded.
    assign w_unused_addr = ^PADDR[1:0];

    assign w_sel    = reg_sel_e'(PADDR[4:2]);
    assign w_mapped = (PADDR[ADDR_W-1:5] == '0) && (w_sel != A_NONE);
    assign w_wr     = PSEL && PENABLE && PWRITE && w_mapped;

    assign PREADY   = 1'b1;
    assign PSLVERR  = PSEL && PENABLE && !w_mapped;

    assign w_rise   = r_sync2 & ~r_prev;
    assign w_fall   = ~r_sync2 & r_prev;
    assign w_event  = r_inte & ((r_ptrig & w_rise) | (~r_ptrig & w_fall));
    assign w_clr    = (w_wr && w_sel == A_INTS) ? PWDATA[GPIO_W-1:0] : '0;

    always_comb begin
        w_rdata = '0;
        if (PSEL && !PWRITE && w_mapped) begin
            case (w_sel)
                A_IN:    w_rdata[GPIO_W-1:0] = r_sync2;
                A_OUT:   w_rdata[GPIO_W-1:0] = r_out;
                A_OE:    w_rdata[GPIO_W-1:0] = r_oe;
                A_INTE:  w_rdata[GPIO_W-1:0] = r_inte;
                A_PTRIG: w_rdata[GPIO_W-1:0] = r_ptrig;
                A_INTS:  w_rdata[GPIO_W-1:0] = r_ints;
                A_CTRL:  w_rdata[0]          = r_ctrl;
                default: w_rdata = '0;
            endcase
        end
    end

    assign PRDATA      = w_rdata;
    assign out_pad_o   = r_out;
    assign oen_padoe_o = r_oe;
    assign irq_o       = r_ctrl && (r_ints != '0);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_out   <= '0;
            r_oe    <= '0;
            r_inte  <= '0;
            r_ptrig <= '0;
            r_ints  <= '0;
            r_ctrl  <= 1'b0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= in_pad_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // A new edge event wins over a same-cycle W1C of that bit.
            r_ints  <= w_event | (r_ints & ~w_clr);
            if (w_wr) begin
                case (w_sel)
                    A_OUT:   r_out   <= PWDATA[GPIO_W-1:0];
                    A_OE:    r_oe    <= PWDATA[GPIO_W-1:0];
                    A_INTE:  r_inte  <= PWDATA[GPIO_W-1:0];
                    A_PTRIG: r_ptrig <= PWDATA[GPIO_W-1:0];
                    A_CTRL:  r_ctrl  <= PWDATA[0];
                    default: ;
                endcase
            end
        end
    end

endmodule
